// File: rtl/player_ctrl_if.sv
// Player-control bus: board buttons, frame pulse and bullet status in;
// ship position and fire request out.
interface player_ctrl_if;
    logic               fsync;
    logic               btn_left;
    logic               btn_right;
    logic               btn_fire;
    logic               bullet_active;
    logic signed [11:0] player_x;
    logic               fire;

    modport master (
        output fsync, btn_left, btn_right, btn_fire, bullet_active,
        input  player_x, fire
    );

    modport slave (
        input  fsync, btn_left, btn_right, btn_fire, bullet_active,
        output player_x, fire
    );
endinterface

// File: rtl/player_ctrl.sv
// Player ship controller: synchronises and debounces the buttons, moves the
// ship once per frame with edge clamping, and issues one fire request per press.
module player_ctrl #(
    parameter int HRES            = 640,
    parameter int PLAYER_W        = 32,
    parameter int SPEED           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic          pixel_clk,
    input  logic          rst,
    player_ctrl_if.slave  bus
);
  localparam int X_MAX = HRES - PLAYER_W;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic signed [12:0] SPEED_S = 13'(SPEED);
  localparam logic signed [12:0] XMAX_S  = 13'(X_MAX);
  localparam logic signed [11:0] X_RST   = 12'(X_MAX / 2);

  // Bit order: 0 = left, 1 = right, 2 = fire.
  logic [2:0] btn_raw;
  logic [2:0] db_state;
  assign btn_raw = {bus.btn_fire, bus.btn_right, bus.btn_left};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic            sync1_reg;
      logic            sync2_reg;
      logic            stable_reg;
      logic [DB_W-1:0] cnt_reg;

      // The count tracks consecutive synchronised samples that disagree with
      // the accepted state; any agreeing sample restarts it.
      always_ff @(posedge pixel_clk) begin
        if (rst) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + DB_W'(1);
          end
        end
      end

      assign db_state[gi] = stable_reg;
    end
  endgenerate

  logic signed [11:0] x_reg;
  logic signed [11:0] x_next;
  logic signed [12:0] x_ext;
  logic signed [12:0] x_dec;
  logic signed [12:0] x_inc;

  // One extra bit of headroom so stepping past either edge cannot wrap.
  always_comb begin
    x_ext  = {x_reg[11], x_reg};
    x_dec  = x_ext - SPEED_S;
    x_inc  = x_ext + SPEED_S;
    x_next = x_reg;
    if (bus.fsync) begin
      if (db_state[0] && !db_state[1]) begin
        x_next = (x_dec < 13'sd0) ? 12'sd0 : x_dec[11:0];
      end else if (db_state[1] && !db_state[0]) begin
        x_next = (x_inc > XMAX_S) ? XMAX_S[11:0] : x_inc[11:0];
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) x_reg <= X_RST;
    else     x_reg <= x_next;
  end

  typedef enum logic [1:0] {ST_READY, ST_FIRE, ST_COOLDOWN, ST_RELEASE} state_t;

  state_t          state_reg;
  logic            fire_reg;
  logic [CD_W-1:0] cooldown_reg;
  logic            db_fire_d_reg;
  logic            fire_rise;

  assign fire_rise = db_state[2] & ~db_fire_d_reg;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_reg     <= ST_READY;
      fire_reg      <= 1'b0;
      cooldown_reg  <= '0;
      db_fire_d_reg <= 1'b0;
    end else begin
      db_fire_d_reg <= db_state[2];
      case (state_reg)
        ST_READY: begin
          // A press while a bullet is in flight is dropped, not queued.
          if (fire_rise && !bus.bullet_active && cooldown_reg == '0) begin
            state_reg <= ST_FIRE;
            fire_reg  <= 1'b1;
          end
        end
        ST_FIRE: begin
          if (bus.fsync) begin
            fire_reg <= 1'b0;
            if (COOLDOWN_FRAMES == 0) begin
              state_reg <= ST_RELEASE;
            end else begin
              state_reg    <= ST_COOLDOWN;
              cooldown_reg <= CD_W'(COOLDOWN_FRAMES);
            end
          end
        end
        ST_COOLDOWN: begin
          if (bus.fsync) begin
            cooldown_reg <= cooldown_reg - CD_W'(1);
            if (cooldown_reg <= CD_W'(1)) state_reg <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!db_state[2]) state_reg <= ST_READY;
        end
        default: state_reg <= ST_READY;
      endcase
    end
  end

  assign bus.player_x = x_reg;
  assign bus.fire     = fire_reg;
endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: a behavioural model queues the expected
// position/fire after every clock edge and a monitor compares them.
module tb_player_ctrl;
  localparam int HRES  = 640;
  localparam int PW    = 32;
  localparam int SPEED = 4;
  localparam int DB    = 4;
  localparam int CD    = 8;
  localparam int FRAME = 16;
  localparam int XMAX  = HRES - PW;
  localparam int XRST  = XMAX / 2;

  logic pixel_clk = 1'b0;
  logic rst = 1'b1;

  player_ctrl_if bus ();

  player_ctrl #(
    .HRES(HRES), .PLAYER_W(PW), .SPEED(SPEED),
    .DEBOUNCE_CYCLES(DB), .COOLDOWN_FRAMES(CD)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 pixel_clk = ~pixel_clk;

  int frame_cnt = 0;
  always @(negedge pixel_clk) begin
    frame_cnt = (frame_cnt + 1) % FRAME;
    bus.fsync = (frame_cnt == 0);
  end

  typedef struct {
    int x;
    bit f;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int fire_pulses = 0;
  bit fire_prev = 1'b0;

  // Reference model: debounced level flips once the last DB synchronised
  // samples all disagree with it; shot lifecycle tracked as plain flags/counts.
  int          m_x;
  bit          m_s1 [3];
  bit          m_s2 [3];
  bit          m_db [3];
  logic [DB-1:0] m_hist [3];
  bit          m_db_d;
  bit          m_shot;
  int          m_frames;
  bit          m_need_rel;

  always @(posedge pixel_clk) begin : model
    bit   rise, l, r;
    bit   raw [3];
    exp_t e;
    cyc++;
    raw[0] = bus.btn_left;
    raw[1] = bus.btn_right;
    raw[2] = bus.btn_fire;
    if (rst) begin
      m_x = XRST;
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_hist[b] = '0;
      end
      m_db_d = 0; m_shot = 0; m_frames = 0; m_need_rel = 0;
    end else begin
      rise = m_db[2] && !m_db_d;
      l = m_db[0];
      r = m_db[1];
      if (m_shot) begin
        if (bus.fsync) begin
          m_shot = 0; m_frames = CD; m_need_rel = 1;
        end
      end else if (m_frames > 0) begin
        if (bus.fsync) m_frames--;
      end else if (m_need_rel) begin
        if (!m_db[2]) m_need_rel = 0;
      end else if (rise && !bus.bullet_active) begin
        m_shot = 1;
      end
      if (bus.fsync) begin
        if (l && !r)      m_x = (m_x - SPEED < 0) ? 0 : m_x - SPEED;
        else if (r && !l) m_x = (m_x + SPEED > XMAX) ? XMAX : m_x + SPEED;
      end
      m_db_d = m_db[2];
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
        if (m_hist[b] == {DB{~m_db[b]}}) begin
          m_db[b] = ~m_db[b];
          m_hist[b] = {DB{m_db[b]}};
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
    e.x = m_x; e.f = m_shot; e.cyc = cyc;
    sb_q.push_back(e);
  end

  always @(negedge pixel_clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compared++;
      if ($isunknown(bus.player_x) || $isunknown(bus.fire) ||
          int'($signed(bus.player_x)) != e.x || bus.fire != e.f) begin
        mismatched++;
        $display("FAIL sb cyc=%0d player_x=%0d fire=%0b expected player_x=%0d fire=%0b",
                 e.cyc, $signed(bus.player_x), bus.fire, e.x, e.f);
      end
      if (bus.fire === 1'b1 && !fire_prev) fire_pulses++;
      fire_prev = (bus.fire === 1'b1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge pixel_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_fire(input string name, input int budget);
    int n = 0;
    while (bus.fire !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(bus.fire === 1'b1), 1);
  endtask

  initial begin : timeout
    #5_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    int p0;
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_fire = 0; bus.bullet_active = 0;
    rst = 1;
    tick(5);
    check("reset_x", int'($signed(bus.player_x)), XRST);
    check("reset_fire", int'(bus.fire), 0);
    rst = 0;
    tick(2);

    bus.btn_right = 1;
    tick(200 * FRAME);
    check("right_sat", int'($signed(bus.player_x)), XMAX);
    bus.btn_right = 0; bus.btn_left = 1;
    tick(200 * FRAME);
    check("left_sat", int'($signed(bus.player_x)), 0);
    bus.btn_left = 0; bus.btn_right = 1;
    tick(30 * FRAME);
    bus.btn_left = 1;
    tick(2 * FRAME);
    p0 = int'($signed(bus.player_x));
    tick(10 * FRAME);
    check("both_hold", int'($signed(bus.player_x)), p0);
    bus.btn_left = 0; bus.btn_right = 0;
    tick(2 * FRAME);

    p0 = fire_pulses;
    bus.btn_fire = 1; tick(DB - 1); bus.btn_fire = 0;
    tick(3 * FRAME);
    check("glitch_no_fire", fire_pulses - p0, 0);

    bus.btn_fire = 1;
    tick(DB + 2);
    check("latency_before", int'(bus.fire), 0);
    tick(1);
    check("latency_at", int'(bus.fire), 1);
    bus.btn_fire = 0;
    tick(3 * FRAME);
    p0 = fire_pulses;
    bus.btn_fire = 1; tick(2 * FRAME); bus.btn_fire = 0;
    tick(FRAME);
    check("cooldown_ignored", fire_pulses - p0, 0);
    tick(8 * FRAME);
    bus.btn_fire = 1;
    wait_fire("after_cooldown", DB + 6);
    bus.btn_fire = 0;
    tick(12 * FRAME);

    p0 = fire_pulses;
    bus.btn_fire = 1; tick(40 * FRAME); bus.btn_fire = 0;
    tick(12 * FRAME);
    check("hold_one_pulse", fire_pulses - p0, 1);

    p0 = fire_pulses;
    bus.bullet_active = 1; bus.btn_fire = 1;
    tick(2 * FRAME);
    bus.bullet_active = 0;
    tick(2 * FRAME);
    check("bullet_blocked", fire_pulses - p0, 0);
    bus.btn_fire = 0; tick(FRAME);
    bus.btn_fire = 1;
    wait_fire("repress_fire", DB + 6);

    rst = 1;
    tick(1);
    check("rst_mid_fire", int'(bus.fire), 0);
    check("rst_mid_x", int'($signed(bus.player_x)), XRST);
    rst = 0; bus.btn_fire = 0;
    tick(3);

    for (int i = 0; i < 300; i++) begin
      bus.btn_left      = 1'($urandom_range(0, 1));
      bus.btn_right     = 1'($urandom_range(0, 1));
      bus.btn_fire      = 1'($urandom_range(0, 1));
      bus.bullet_active = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) rst = 1;
      tick(1);
      rst = 0;
      tick($urandom_range(0, 40));
    end
    bus.btn_left = 0; bus.btn_right = 0; bus.btn_fire = 0; bus.bullet_active = 0;
    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
